vga_tx: RTL and testbench
=========================

// Module: vga_tx
// PURPOSE
//  VGA output stage downstream of the capture path. Reads the greyscale framebuffer that
//  the capture side fills over the second BRAM port. Generates 640x480@60 sync timing and
//  places the SRC_W x SRC_H image inside a fixed window. Outside the window it drives BORDER.
// PARAMETERS
//  H_ACT 640, H_FP 16, H_SYNC 96, H_BP 48 : horizontal timing, pixels
//  V_ACT 480, V_FP 10, V_SYNC 2, V_BP 33  : vertical timing, lines
//  WIN_X0 256, WIN_Y0 176                 : top-left of image window, in active coordinates
//  SRC_W 128, SRC_H 128                   : image size; SRC_W*SRC_H <= 16384 (elaboration error otherwise)
//  BORDER 8'h00                           : pixel value outside the window
//  SYNC_POL 0                             : HS/VS active level (0 = active-low)
// PORTS
//  V_CLK       in   1   pixel clock, 25.175 MHz; all logic on posedge
//  RST         in   1   synchronous, active-high reset
//  ENABLE      in   1   1 = show image; 0 = VGA_PIX forced 0, timing keeps running
//  BRAM_ADDR   out  14  framebuffer read address (registered)
//  BRAM_DOUT   in   8   read data, valid 1 cycle after BRAM_ADDR
//  VGA_HS      out  1   horizontal sync
//  VGA_VS      out  1   vertical sync
//  VGA_DE      out  1   active-video flag
//  VGA_PIX     out  8   greyscale pixel to DAC
//  FRAME_START out  1   1-cycle pulse aligned with the first active pixel of each frame
// BEHAVIOUR
//  - Counters: h 0..799 (10b), v 0..524 (10b). Active region is h<H_ACT, v<V_ACT.
//    h wraps to 0 and increments v; v wraps to 0 after line 524.
//  - HS active for H_ACT+H_FP <= h < H_ACT+H_FP+H_SYNC; VS likewise on v.
//  - in_win = WIN_X0<=h<WIN_X0+SRC_W && WIN_Y0<=v<WIN_Y0+SRC_H.
//  - Pipeline for the counter state at cycle N:
//    - N+1: BRAM_ADDR registered.
//    - N+2: BRAM_DOUT valid.
//    - N+3: VGA_PIX/HS/VS/DE/FRAME_START registered. All outputs share the 3-cycle latency.
//  - Read pointer ptr (14b):
//    - At h==0,v==0: ptr<=0.
//    - When in_win: BRAM_ADDR<=ptr and ptr<=ptr+1.
//    - Otherwise BRAM_ADDR holds its last value.
//    - Raster order gives address = (v-WIN_Y0)*SRC_W + (h-WIN_X0). ptr wraps modulo 2^14.
//  - VGA_PIX at N+3:
//    - 0 if !de or !ENABLE.
//    - Else BRAM_DOUT if the delayed in_win flag is set.
//    - Else BORDER.
//  - ENABLE is sampled at stage N+2. Toggling it mid-line takes effect on the next pixel.
//  - Reset:
//    - h=v=0, ptr=0, BRAM_ADDR=0, pipeline flushed.
//    - VGA_HS=VGA_VS=!SYNC_POL, VGA_DE=0, VGA_PIX=0, FRAME_START=0.
//    - Reset mid-frame restarts the frame at h=v=0 on the cycle after RST falls; no partial
//      output is held.
//  - BRAM_DOUT is only consumed inside the window. Capture-side writes racing a read give
//    either old or new data (tearing accepted).
// CONFIGURATION
//  SCANLINE_EN defined:
//    - On odd window rows ((v-WIN_Y0) odd), VGA_PIX = BRAM_DOUT>>1. Border and even rows
//      are unchanged. Latency is unchanged.
//  SCANLINE_EN undefined: all window rows pass BRAM_DOUT unmodified.
// STRUCTURE
//  - Package vga_timing_pkg holds the 640x480 timing constants, the counter widths
//    (10/10) and FB_ADDR_W=14.
//  - The capture side imports FB_ADDR_W from the same package.
//  - Sub-module vga_timing_gen provides the h/v counters plus the hs/vs/de/frame_start
//    decode. vga_tx owns the window, ptr, pipeline and pixel mux.
// TESTING
//  - Reset: hold RST 5 cycles -> all outputs at reset values; FRAME_START pulses 3 cycles
//    after RST falls.
//  - Timing: run 2 frames -> HS active 96 cycles every 800; VS active 2 lines (1600 cycles)
//    every 525 lines; DE high 640 cycles/line on 480 lines.
//  - Mapping: BRAM model mem[a]=a[7:0], 1-cycle latency:
//    - First window pixel (h=256,v=176) -> VGA_PIX=0x00 at counter+3.
//    - Next pixel -> 0x01.
//    - Row 1 col 0 -> BRAM_ADDR=128.
//    - Last pixel -> BRAM_ADDR=16383.
//  - Border: BORDER=8'h55 -> h=255/384 or v=175/304 inside active region give 0x55;
//    blanking gives 0x00.
//  - ENABLE low for one frame -> VGA_PIX=0 throughout, HS/VS/DE identical to the enabled frame.
//  - RST mid-line (h=400,v=200) -> next frame starts cleanly; ptr restarts at 0.
//    With SCANLINE_EN, window row 1 reading 0xFE outputs 0x7F.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - 640x480@60 timing constants, counter widths and framebuffer address width
package vga_timing_pkg;
    localparam int VGA_H_ACT  = 640;
    localparam int VGA_H_FP   = 16;
    localparam int VGA_H_SYNC = 96;
    localparam int VGA_H_BP   = 48;
    localparam int VGA_V_ACT  = 480;
    localparam int VGA_V_FP   = 10;
    localparam int VGA_V_SYNC = 2;
    localparam int VGA_V_BP   = 33;

    localparam int H_CNT_W   = 10;
    localparam int V_CNT_W   = 10;
    localparam int FB_ADDR_W = 14;

    typedef logic [H_CNT_W-1:0]   hcnt_t;
    typedef logic [V_CNT_W-1:0]   vcnt_t;
    typedef logic [FB_ADDR_W-1:0] fb_addr_t;

    // Per-pixel control that rides alongside the framebuffer read
    typedef struct packed {
        logic hs;
        logic vs;
        logic de;
        logic frame_start;
        logic in_win;
        logic odd_row;
    } pix_ctl_t;

    function automatic logic sync_level(input logic active, input logic pol);
        return active ? pol : ~pol;
    endfunction
endpackage

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - h/v raster counters with combinational hs/vs/de/frame_start decode
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int   H_ACT    = VGA_H_ACT,
    parameter int   H_FP     = VGA_H_FP,
    parameter int   H_SYNC   = VGA_H_SYNC,
    parameter int   H_BP     = VGA_H_BP,
    parameter int   V_ACT    = VGA_V_ACT,
    parameter int   V_FP     = VGA_V_FP,
    parameter int   V_SYNC   = VGA_V_SYNC,
    parameter int   V_BP     = VGA_V_BP,
    parameter logic SYNC_POL = 1'b0
) (
    input  logic  V_CLK,
    input  logic  RST,
    output hcnt_t h,
    output vcnt_t v,
    output logic  hs,
    output logic  vs,
    output logic  de,
    output logic  frame_start
);
    localparam hcnt_t H_LAST   = hcnt_t'(H_ACT + H_FP + H_SYNC + H_BP - 1);
    localparam vcnt_t V_LAST   = vcnt_t'(V_ACT + V_FP + V_SYNC + V_BP - 1);
    localparam hcnt_t H_ACT_C  = hcnt_t'(H_ACT);
    localparam vcnt_t V_ACT_C  = vcnt_t'(V_ACT);
    localparam hcnt_t HS_ON    = hcnt_t'(H_ACT + H_FP);
    localparam hcnt_t HS_OFF   = hcnt_t'(H_ACT + H_FP + H_SYNC);
    localparam vcnt_t VS_ON    = vcnt_t'(V_ACT + V_FP);
    localparam vcnt_t VS_OFF   = vcnt_t'(V_ACT + V_FP + V_SYNC);

    always_ff @(posedge V_CLK) begin
        if (RST) begin
            h <= '0;
            v <= '0;
        end else if (h == H_LAST) begin
            h <= '0;
            v <= (v == V_LAST) ? '0 : v + vcnt_t'(1);
        end else begin
            h <= h + hcnt_t'(1);
        end
    end

    assign de          = (h < H_ACT_C) && (v < V_ACT_C);
    assign hs          = sync_level((h >= HS_ON) && (h < HS_OFF), SYNC_POL);
    assign vs          = sync_level((v >= VS_ON) && (v < VS_OFF), SYNC_POL);
    assign frame_start = (h == '0) && (v == '0);
endmodule

// File: rtl/vga_tx.sv
// rtl/vga_tx.sv - VGA output stage: windowed greyscale framebuffer scan-out, 3-cycle pipeline
// Optional SCANLINE_EN: halve pixel value on odd window rows.
module vga_tx
    import vga_timing_pkg::*;
#(
    parameter int         H_ACT    = VGA_H_ACT,
    parameter int         H_FP     = VGA_H_FP,
    parameter int         H_SYNC   = VGA_H_SYNC,
    parameter int         H_BP     = VGA_H_BP,
    parameter int         V_ACT    = VGA_V_ACT,
    parameter int         V_FP     = VGA_V_FP,
    parameter int         V_SYNC   = VGA_V_SYNC,
    parameter int         V_BP     = VGA_V_BP,
    parameter int         WIN_X0   = 256,
    parameter int         WIN_Y0   = 176,
    parameter int         SRC_W    = 128,
    parameter int         SRC_H    = 128,
    parameter logic [7:0] BORDER   = 8'h00,
    parameter logic       SYNC_POL = 1'b0
) (
    input  logic                 V_CLK,
    input  logic                 RST,
    input  logic                 ENABLE,
    output logic [FB_ADDR_W-1:0] BRAM_ADDR,
    input  logic [7:0]           BRAM_DOUT,
    output logic                 VGA_HS,
    output logic                 VGA_VS,
    output logic                 VGA_DE,
    output logic [7:0]           VGA_PIX,
    output logic                 FRAME_START
);
    generate
        if (SRC_W * SRC_H > 2 ** FB_ADDR_W) begin : g_size_check
            $error("vga_tx: SRC_W*SRC_H does not fit the framebuffer address space");
        end
    endgenerate

`ifdef SCANLINE_EN
    localparam logic SCANLINE = 1'b1;
`else
    localparam logic SCANLINE = 1'b0;
`endif

    localparam hcnt_t    WIN_X_LO = hcnt_t'(WIN_X0);
    localparam hcnt_t    WIN_X_HI = hcnt_t'(WIN_X0 + SRC_W);
    localparam vcnt_t    WIN_Y_LO = vcnt_t'(WIN_Y0);
    localparam vcnt_t    WIN_Y_HI = vcnt_t'(WIN_Y0 + SRC_H);
    localparam pix_ctl_t CTL_IDLE = pix_ctl_t'{~SYNC_POL, ~SYNC_POL, 1'b0, 1'b0, 1'b0, 1'b0};

    hcnt_t    h;
    vcnt_t    v;
    logic     t_hs, t_vs, t_de, t_fs;
    logic     in_win;
    fb_addr_t ptr, ptr_base;
    pix_ctl_t ctl0, ctl1, ctl2;
    logic [7:0] pix_next;

    vga_timing_gen #(
        .H_ACT    (H_ACT),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACT    (V_ACT),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP),
        .SYNC_POL (SYNC_POL)
    ) u_timing (
        .V_CLK       (V_CLK),
        .RST         (RST),
        .h           (h),
        .v           (v),
        .hs          (t_hs),
        .vs          (t_vs),
        .de          (t_de),
        .frame_start (t_fs)
    );

    assign in_win = (h >= WIN_X_LO) && (h < WIN_X_HI) && (v >= WIN_Y_LO) && (v < WIN_Y_HI);

    // Raster order inside the window makes a running pointer equal to row*SRC_W+col
    assign ptr_base = t_fs ? '0 : ptr;

    assign ctl0 = pix_ctl_t'{t_hs, t_vs, t_de, t_fs, in_win, v[0] ^ WIN_Y_LO[0]};

    always_comb begin
        pix_next = BORDER;
        if (!ctl2.de || !ENABLE) begin
            pix_next = '0;
        end else if (ctl2.in_win) begin
            pix_next = (SCANLINE && ctl2.odd_row) ? (BRAM_DOUT >> 1) : BRAM_DOUT;
        end
    end

    always_ff @(posedge V_CLK) begin
        if (RST) begin
            ptr         <= '0;
            BRAM_ADDR   <= '0;
            ctl1        <= CTL_IDLE;
            ctl2        <= CTL_IDLE;
            VGA_HS      <= ~SYNC_POL;
            VGA_VS      <= ~SYNC_POL;
            VGA_DE      <= 1'b0;
            VGA_PIX     <= '0;
            FRAME_START <= 1'b0;
        end else begin
            if (in_win) begin
                BRAM_ADDR <= ptr_base;
                ptr       <= ptr_base + fb_addr_t'(1);
            end else begin
                ptr       <= ptr_base;
            end
            ctl1        <= ctl0;
            ctl2        <= ctl1;
            VGA_HS      <= ctl2.hs;
            VGA_VS      <= ctl2.vs;
            VGA_DE      <= ctl2.de;
            VGA_PIX     <= pix_next;
            FRAME_START <= ctl2.frame_start;
        end
    end
endmodule

// File: tb/tb_vga_tx.sv
// tb/tb_vga_tx.sv - self-checking bench for vga_tx on scaled-down timing with a full 128x128 window
module tb_vga_tx;
    localparam int HA = 136, HF = 2, HSW = 4, HB = 2;
    localparam int VA = 136, VF = 1, VSW = 2, VB = 1;
    localparam int HT = HA + HF + HSW + HB;
    localparam int VT = VA + VF + VSW + VB;
    localparam int FRAME = HT * VT;
    localparam int WX = 4, WY = 4, SW = 128, SH = 128;
    localparam logic [7:0] BORDER = 8'h55;
`ifdef SCANLINE_EN
    localparam bit SCAN = 1'b1;
`else
    localparam bit SCAN = 1'b0;
`endif

    logic        V_CLK = 1'b0;
    logic        RST = 1'b1;
    logic        ENABLE = 1'b1;
    logic [13:0] BRAM_ADDR;
    logic [7:0]  BRAM_DOUT = 8'h00;
    logic        VGA_HS, VGA_VS, VGA_DE, FRAME_START;
    logic [7:0]  VGA_PIX;

    vga_tx #(
        .H_ACT (HA), .H_FP (HF), .H_SYNC (HSW), .H_BP (HB),
        .V_ACT (VA), .V_FP (VF), .V_SYNC (VSW), .V_BP (VB),
        .WIN_X0 (WX), .WIN_Y0 (WY), .SRC_W (SW), .SRC_H (SH),
        .BORDER (BORDER), .SYNC_POL (1'b0)
    ) dut (
        .V_CLK       (V_CLK),
        .RST         (RST),
        .ENABLE      (ENABLE),
        .BRAM_ADDR   (BRAM_ADDR),
        .BRAM_DOUT   (BRAM_DOUT),
        .VGA_HS      (VGA_HS),
        .VGA_VS      (VGA_VS),
        .VGA_DE      (VGA_DE),
        .VGA_PIX     (VGA_PIX),
        .FRAME_START (FRAME_START)
    );

    always #20 V_CLK = ~V_CLK;

    // Framebuffer holds mem[a] = a[7:0], one-cycle read latency
    always @(posedge V_CLK) BRAM_DOUT <= BRAM_ADDR[7:0];

    int cyc = 0;
    bit started = 1'b0;
    always @(posedge V_CLK) begin
        started <= 1'b1;
        cyc     <= RST ? 0 : cyc + 1;
    end

    int checks = 0;
    int passed = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s at cyc %0d: got %0d expected %0d", name, cyc, act, exp);
    endtask

    function automatic int pos(input int h, input int v);
        return v * HT + h;
    endfunction

    function automatic bit win(input int s);
        int h = s % HT;
        int v = s / HT;
        return (h >= WX) && (h < WX + SW) && (v >= WY) && (v < WY + SH);
    endfunction

    function automatic int waddr(input int s);
        return ((s / HT) - WY) * SW + ((s % HT) - WX);
    endfunction

    function automatic void model(input int s, input bit en, output bit hs, output bit vs,
                                  output bit de, output bit fs, output int pix);
        int h = s % HT;
        int v = s / HT;
        int a;
        hs = !(h >= HA + HF && h < HA + HF + HSW);
        vs = !(v >= VA + VF && v < VA + VF + VSW);
        de = (h < HA) && (v < VA);
        fs = (s == 0);
        if (!de || !en) pix = 0;
        else if (win(s)) begin
            a   = waddr(s) % 256;
            pix = (SCAN && ((v - WY) % 2 == 1)) ? a / 2 : a;
        end else pix = BORDER;
    endfunction

    bit en_prev = 1'b1;
    int exp_addr = 0;
    bit first_run = 1'b1;
    int hs_a = 0, vs_a = 0, de_a = 0, hs_b = 0, vs_b = 0, de_b = 0, pixnz_b = 0;

    always @(negedge V_CLK) begin
        bit e_hs, e_vs, e_de, e_fs;
        int e_pix;
        if (started) begin
            if (cyc == 0) exp_addr = 0;
            else if (win((cyc - 1) % FRAME)) exp_addr = waddr((cyc - 1) % FRAME);
            if (cyc < 3) begin
                e_hs = 1'b1; e_vs = 1'b1; e_de = 1'b0; e_fs = 1'b0; e_pix = 0;
            end else begin
                model((cyc - 3) % FRAME, en_prev, e_hs, e_vs, e_de, e_fs, e_pix);
            end
            check("hs", int'(VGA_HS), int'(e_hs));
            check("vs", int'(VGA_VS), int'(e_vs));
            check("de", int'(VGA_DE), int'(e_de));
            check("frame_start", int'(FRAME_START), int'(e_fs));
            check("pix", int'(VGA_PIX), e_pix);
            check("bram_addr", int'(BRAM_ADDR), exp_addr);
            if (first_run && cyc >= 3 && cyc < FRAME + 3) begin
                hs_a += int'(!VGA_HS); vs_a += int'(!VGA_VS); de_a += int'(VGA_DE);
            end else if (first_run && cyc >= FRAME + 3 && cyc < 2 * FRAME + 3) begin
                hs_b += int'(!VGA_HS); vs_b += int'(!VGA_VS); de_b += int'(VGA_DE);
                pixnz_b += int'(VGA_PIX != 8'h00);
            end
            en_prev = ENABLE;
        end
    end

    task automatic wait_cyc(input int n);
        int guard = 0;
        do begin
            @(negedge V_CLK);
            guard++;
        end while (cyc != n && guard < 50000);
        if (cyc != n) begin
            checks++;
            $display("FAIL wait_cyc: reached %0d expected %0d", cyc, n);
        end
    endtask

    initial begin
        RST = 1'b1;
        ENABLE = 1'b1;
        repeat (5) @(posedge V_CLK);
        @(negedge V_CLK);
        check("rst_hs", int'(VGA_HS), 1);
        check("rst_vs", int'(VGA_VS), 1);
        check("rst_de", int'(VGA_DE), 0);
        check("rst_pix", int'(VGA_PIX), 0);
        check("rst_fs", int'(FRAME_START), 0);
        check("rst_addr", int'(BRAM_ADDR), 0);
        @(posedge V_CLK); #1 RST = 1'b0;

        wait_cyc(3);                   check("lit_fs_after_rst", int'(FRAME_START), 1);
        wait_cyc(pos(HA, 0) + 3);      check("lit_blank_pix", int'(VGA_PIX), 0);
        wait_cyc(pos(WX, WY - 1) + 3); check("lit_border_top", int'(VGA_PIX), 8'h55);
        wait_cyc(pos(WX - 1, WY) + 3); check("lit_border_left", int'(VGA_PIX), 8'h55);
        wait_cyc(pos(WX, WY) + 3);     check("lit_first_pix", int'(VGA_PIX), 8'h00);
        wait_cyc(pos(WX + 1, WY) + 3); check("lit_second_pix", int'(VGA_PIX), 8'h01);
        wait_cyc(pos(WX + SW, WY) + 3); check("lit_border_right", int'(VGA_PIX), 8'h55);
        wait_cyc(pos(WX, WY + 1) + 1); check("lit_row1_addr", int'(BRAM_ADDR), 128);
        wait_cyc(pos(WX + 126, WY + 1) + 3);
        check("lit_row1_fe", int'(VGA_PIX), SCAN ? 8'h7F : 8'hFE);
        wait_cyc(pos(WX + 127, WY + 127) + 1); check("lit_last_addr", int'(BRAM_ADDR), 16383);
        wait_cyc(pos(WX, WY + SH) + 3); check("lit_border_bottom", int'(VGA_PIX), 8'h55);

        wait_cyc(FRAME + 1);
        @(posedge V_CLK); #1 ENABLE = 1'b0;
        wait_cyc(2 * FRAME + 1);
        @(posedge V_CLK); #1 ENABLE = 1'b1;
        wait_cyc(2 * FRAME + 3);
        first_run = 1'b0;
        check("cnt_hs_en", hs_a, 560);
        check("cnt_vs_en", vs_a, 288);
        check("cnt_de_en", de_a, 18496);
        check("cnt_hs_dis", hs_b, 560);
        check("cnt_vs_dis", vs_b, 288);
        check("cnt_de_dis", de_b, 18496);
        check("cnt_pix_dis", pixnz_b, 0);

        wait_cyc(2 * FRAME + pos(WX + 60, WY + 6) - 1);
        @(posedge V_CLK); #1 RST = 1'b1;
        repeat (3) @(posedge V_CLK);
        #1 RST = 1'b0;
        wait_cyc(3);                   check("lit_fs_after_midrst", int'(FRAME_START), 1);
        wait_cyc(pos(WX + 1, WY) + 3); check("lit_midrst_second_pix", int'(VGA_PIX), 8'h01);
        wait_cyc(pos(WX, WY + 1) + 1); check("lit_midrst_row1_addr", int'(BRAM_ADDR), 128);
        wait_cyc(pos(WX + 126, WY + 1) + 3);
        check("lit_midrst_row1_fe", int'(VGA_PIX), SCAN ? 8'h7F : 8'hFE);

        @(negedge V_CLK);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
